// File: rtl/seq_pc_sequencer.sv
// seq_pc_sequencer: multi-cycle phase controller for the SEQ Y86-64 core.
// Steps FETCH/EXEC/MEM/WB, owns the architectural PC and status code, and
// selects the next PC from per-phase captured values.
// Optional build macro SEQ_PERF_CNT_EN adds retired/stall performance counters.
module seq_pc_sequencer #(
  parameter int                 ADDR_W      = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic [ADDR_W-1:0] valP,
  input  logic [ADDR_W-1:0] valC,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] valM,
  input  logic              mem_ack,
  input  logic              dmem_error,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              exec_en,
  output logic              mem_req,
  output logic              wb_en,
  output logic [2:0]        stat,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              busy
);

  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_HLT  = 3'd2;
  localparam logic [2:0]  STAT_ADR  = 3'd3;
  localparam logic [2:0]  STAT_INS  = 3'd4;
  localparam logic [31:0] TIMEOUT_U = 32'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALTED, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2:0]          stat_q, stat_d;
  logic [3:0]          icode_q, icode_d;
  logic [ADDR_W-1:0]   valp_q, valp_d;
  logic [ADDR_W-1:0]   valc_q, valc_d;
  logic [ADDR_W-1:0]   valm_q, valm_d;
  logic                cnd_q, cnd_d;
  logic [31:0]         wait_q, wait_d;
  logic                restart;
  logic                retire;
  logic                stall;
  logic                needs_mem;
  logic                expired;

  // Opcodes that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  assign needs_mem = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  // Current MEM cycle is the last one allowed; a zero timeout disables the check.
  assign expired   = (MEM_TIMEOUT != 0) && (wait_q >= TIMEOUT_U - 32'd1);

  assign pc   = pc_q;
  assign stat = stat_q;

  // State, PC, status and per-phase capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
      valp_q  <= '0;
      valc_q  <= '0;
      valm_q  <= '0;
      cnd_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      valp_q  <= valp_d;
      valc_q  <= valc_d;
      valm_q  <= valm_d;
      cnd_q   <= cnd_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, next-PC and phase enables.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stat_d   = stat_q;
    icode_d  = icode_q;
    valp_d   = valp_q;
    valc_d   = valc_q;
    valm_d   = valm_q;
    cnd_d    = cnd_q;
    wait_d   = wait_q;
    restart  = 1'b0;
    retire   = 1'b0;
    stall    = 1'b0;
    fetch_en = 1'b0;
    exec_en  = 1'b0;
    mem_req  = 1'b0;
    wb_en    = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        fetch_en = 1'b1;
        icode_d  = icode;
        valp_d   = valP;
        valc_d   = valC;
        if (imem_error) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_ERROR;
          stat_d  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        exec_en = 1'b1;
        cnd_d   = cnd;
        wait_d  = '0;
        state_d = needs_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          valm_d = valM;
          if (dmem_error) begin
            state_d = S_ERROR;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WB;
          end
        end else begin
          stall = 1'b1;
          if (expired) begin
            state_d = S_ERROR;
            stat_d  = STAT_ADR;
          end else if (wait_q != '1) begin
            wait_d = wait_q + 32'd1;
          end
        end
      end
      S_WB: begin
        busy    = 1'b1;
        wb_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (icode_q)
          4'h7:    pc_d = cnd_q ? valc_q : valp_q;
          4'h8:    pc_d = valc_q;
          4'h9:    pc_d = valm_q;
          default: pc_d = valp_q;
        endcase
      end
      S_HALTED, S_ERROR: begin
        if (start) begin
          state_d = S_IDLE;
          pc_d    = RESET_PC;
          stat_d  = STAT_AOK;
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;

  // Saturating retired-instruction and memory-stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else if (restart) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire && retired_q != '1) retired_q <= retired_q + 32'd1;
      if (stall && stall_q != '1)    stall_q   <= stall_q + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = retire ^ stall ^ restart;
`endif

endmodule

// File: tb/tb_seq_pc_sequencer.sv
// Self-checking bench for seq_pc_sequencer: expected outcomes of each
// instruction are queued when it is driven and compared when it completes.
module tb_seq_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, instr_valid, imem_error, cnd, mem_ack, dmem_error;
  logic [3:0]  icode;
  logic [63:0] valP, valC, valM, pc;
  logic        fetch_en, exec_en, mem_req, wb_en, busy;
  logic [2:0]  stat;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  seq_pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .valP(valP), .valC(valC),
    .cnd(cnd), .valM(valM), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .pc(pc), .fetch_en(fetch_en), .exec_en(exec_en), .mem_req(mem_req),
    .wb_en(wb_en), .stat(stat),
`ifdef SEQ_PERF_CNT_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    int          cycles;
    int          memc;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // IDLE -> FETCH
  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // HALTED/ERROR -> IDLE with PC and status back at reset values
  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_pc = 64'h0;
    chk("restart_busy", 64'(busy), 64'd0);
    chk("restart_pc", pc, 64'h0);
    chk("restart_stat", 64'(stat), 64'd1);
  endtask

  // Runs one instruction starting at a negedge in FETCH. ack_after = number of
  // MEM wait cycles before mem_ack (negative: never acknowledge).
  task automatic run_instr(input logic [3:0] ic, input logic [63:0] vp, input logic [63:0] vc,
                           input logic [63:0] vm, input logic c, input int ack_after,
                           input logic dme, input logic iv, input logic ime,
                           input logic hold_start);
    exp_t e;
    exp_t got;
    int   cyc;
    int   memc;
    e.pc = model_pc; e.stat = 3'd1; e.memc = 0; e.cycles = 1;
    if (ime)            e.stat = 3'd3;
    else if (!iv)       e.stat = 3'd4;
    else if (ic == 0)   e.stat = 3'd2;
    else begin
      if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
        if (ack_after >= 0 && ack_after < 16) begin
          e.memc = ack_after + 1;
          if (dme) begin e.stat = 3'd3; e.cycles = 2 + e.memc; end
          else e.cycles = 3 + e.memc;
        end else begin
          e.memc = 16; e.stat = 3'd3; e.cycles = 18;
        end
      end else e.cycles = 3;
      if (e.stat == 3'd1) begin
        case (ic)
          4'h7:    e.pc = c ? vc : vp;
          4'h8:    e.pc = vc;
          4'h9:    e.pc = vm;
          default: e.pc = vp;
        endcase
      end
    end
    model_pc = e.pc;
    sb_q.push_back(e);

    icode = ic; valP = vp; valC = vc; cnd = c;
    instr_valid = iv; imem_error = ime; start = hold_start;
    chk("fetch_en", 64'(fetch_en), 64'd1);
    cyc = 0; memc = 0;
    do begin
      mem_ack = 1'b0; dmem_error = 1'b0;
      if (mem_req) begin
        if (memc == ack_after) begin
          mem_ack = 1'b1; valM = vm; dmem_error = dme;
        end
        memc++;
      end
      cyc++;
      @(negedge clk);
    end while (busy && !fetch_en && cyc < 100);
    mem_ack = 1'b0; dmem_error = 1'b0; start = 1'b0;

    got = sb_q.pop_front();
    chk("pc", pc, got.pc);
    chk("stat", 64'(stat), 64'(got.stat));
    chk("cycles", 64'(cyc), 64'(got.cycles));
    chk("mem_cycles", 64'(memc), 64'(got.memc));
    $display("instr icode=%h pc=0x%0h stat=%0d cycles=%0d mem_cycles=%0d", ic, pc, stat, cyc, memc);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; icode = '0; instr_valid = 1'b1; imem_error = 1'b0;
    valP = '0; valC = '0; valM = '0; cnd = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
    model_pc = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 64'h0);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_enables", {60'd0, fetch_en, exec_en, mem_req, wb_en}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 64'(busy), 64'd0);

    go();
    run_instr(4'h3, 64'h0A, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);   // irmovq
    run_instr(4'h7, 64'h09, 64'h40, 64'h0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0);  // jXX taken
    run_instr(4'h7, 64'h09, 64'h40, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1);  // jXX not taken, start held
    run_instr(4'h9, 64'h0B, 64'h0, 64'h100, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0);  // ret, 3 waits
    run_instr(4'h8, 64'h109, 64'h200, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0); // call
    run_instr(4'h5, 64'h30, 64'h0, 64'h5, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b0);   // ack on 16th MEM cycle
    run_instr(4'h0, 64'h31, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);   // halt
    restart();

    go();
    run_instr(4'h5, 64'h0A, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);   // mrmovq timeout
    restart();
    go();
    run_instr(4'h4, 64'h0A, 64'h0, 64'h0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);    // rmmovq data fault
    restart();
    go();
    run_instr(4'h3, 64'h0A, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);   // illegal instruction
    restart();
    go();
    run_instr(4'h3, 64'h0A, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(4'h3, 64'h14, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 1'b0);   // fetch fault
    restart();

    // Reset asserted while waiting in MEM aborts with no partial PC update.
    go();
    run_instr(4'h3, 64'h50, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    icode = 4'h5; valP = 64'h60; instr_valid = 1'b1; imem_error = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mem", 64'(mem_req), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_pc", pc, 64'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mem_req", 64'(mem_req), 64'd0);
    chk("abort_stat", 64'(stat), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = 64'h0;
    @(negedge clk);
    go();
    run_instr(4'h3, 64'h0C, 64'h0, 64'h0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
